// File: rtl/div_radix2_if.sv
// Divide-stall handshake between the hazard/E-stage side and the radix-2 divider.
interface div_radix2_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 annul;
  logic                 accept;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;

  modport master (
    output start, signed_div, opdata1, opdata2, annul, accept,
    input  result, ready
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul, accept,
    output result, ready
  );
endinterface

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per cycle.
// Result is {remainder, quotient}, held in DONE until the E stage advances.
module div_radix2 #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  div_radix2_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDivZero, StDivOn, StDone} state_e;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dsr;
  logic [WIDTH-2:0]   r_rem;
  logic [WIDTH-2:0]   r_quot;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH-1:0]   w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quot_nxt;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quot_fix;

  always_comb begin
    w_abs1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    w_abs2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
    // The partial remainder never reaches the top bit before a shift, so W bits suffice.
    w_shift    = {r_rem, r_dvd[WIDTH-1]};
    w_diff     = {1'b0, w_shift} - {1'b0, r_dsr};
    w_qbit     = ~w_diff[WIDTH];
    w_rem_nxt  = w_qbit ? w_diff[WIDTH-1:0] : w_shift;
    w_quot_nxt = {r_quot, w_qbit};
    w_rem_fix  = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    w_quot_fix = r_neg_q ? -w_quot_nxt : w_quot_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else if (bus.annul) begin
      r_state <= StIdle;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_dvd   <= w_abs1;
            r_dsr   <= w_abs2;
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_neg_q <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
            r_neg_r <= bus.signed_div & bus.opdata1[WIDTH-1];
            r_state <= (bus.opdata2 == '0) ? StDivZero : StDivOn;
          end
        end
        StDivZero: begin
          if (!bus.start) begin
            r_state <= StIdle;
          end else begin
            r_result <= '0;
            r_ready  <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDivOn: begin
          if (!bus.start) begin
            r_state <= StIdle;
          end else begin
            r_rem  <= w_rem_nxt[WIDTH-2:0];
            r_quot <= w_quot_nxt[WIDTH-2:0];
            r_dvd  <= r_dvd << 1;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LastCnt) begin
              r_result <= {w_rem_fix, w_quot_fix};
              r_ready  <= 1'b1;
              r_state  <= StDone;
            end
          end
        end
        StDone: begin
          if (bus.accept) begin
            r_ready <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.ready  = r_ready;
endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: stimulus pushes expected results to a scoreboard,
// an independent monitor pops and compares on each rising ready.
module tb_div_radix2;
  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  logic        prev_ready;
  logic [63:0] held_result;

  div_radix2_if #(.WIDTH(32)) bus ();

  div_radix2 #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops an expected entry on every new result, checks stability while held.
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (bus.ready && !prev_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", 64'(bus.ready), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", bus.result, e.res);
          chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        end
      end else if (bus.ready && prev_ready) begin
        chk("result_stable", bus.result, held_result);
      end
      prev_ready  = bus.ready;
      held_result = bus.result;
    end
  end

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int lat, input int hold);
    exp_t e;
    logic got;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.accept     = (hold == 0);
    e.res = exp_res;
    e.lat = lat;
    e.t0  = cyc;
    sb_q.push_back(e);
    // Operands change after sampling, as a forwarding update would.
    @(posedge clk);
    #1;
    bus.opdata1 = ~a;
    bus.opdata2 = b ^ 32'h0000_005A;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = bus.ready;
    end
    chk("ready_seen", 64'(got), 64'd1);
    if (got) begin
      if (hold == 0) begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end else begin
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          chk("ready_held", 64'(bus.ready), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.accept = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      @(negedge clk);
      chk("ready_drop", 64'(bus.ready), 64'd0);
    end else begin
      bus.start  = 1'b0;
      bus.accept = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    cyc            = 0;
    checks         = 0;
    failures       = 0;
    prev_ready     = 1'b0;
    held_result    = '0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    bus.accept     = 1'b1;
    #12;
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'd1, 32'd1}, 33, 0);
    do_div(1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);
    do_div(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 10);

    // Annul at iteration 15: no result may appear.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd12345;
    bus.opdata2    = 32'd7;
    repeat (16) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.ready;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    do_div(1'b0, 32'd12345, 32'd7, {32'd4, 32'd1763}, 33, 0);

    // Reset at iteration 20 clears outputs before the next edge.
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.opdata1 = 32'd500;
    bus.opdata2 = 32'd3;
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", 64'(bus.ready), 64'd0);
    chk("async_rst_result", bus.result, 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div_radix2.md
# div_radix2

Multi-cycle 32-bit integer divider for the execute stage; it is the responder side of the hazard unit's divide-stall handshake. While a DIV/DIVU sits in E, the hazard unit holds `stallE` until this block raises `ready`. The block computes quotient and remainder by radix-2 restoring division, one bit per cycle. It holds its result until the pipeline actually advances the instruction, and it abandons the operation on an exception flush.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Result is 2×WIDTH. The iteration count equals WIDTH.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  E-stage instruction is DIV/DIVU; level, held for the whole operation
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start` in IDLE
- `opdata1`  in  WIDTH  dividend; sampled in IDLE
- `opdata2`  in  WIDTH  divisor; sampled in IDLE
- `annul`  in  1  exception flush of E stage; abort immediately
- `accept`  in  1  E stage advances this cycle (E not stalled by any other source)
- `result`  out  2×WIDTH  {remainder (HI), quotient (LO)}; registered
- `ready`  out  1  result valid; registered

## Operation
- States: IDLE, DIVZERO, DIVON, DONE. The state register resets to IDLE.
- IDLE, `start`=1, `annul`=0:
  - Latch absolute values of the operands when `signed_div`=1, raw values otherwise.
  - Latch the result sign flags.
  - Go to DIVZERO if `opdata2`==0, else go to DIVON with iteration counter = 0.
- DIVON, each cycle:
  - Form a WIDTH+1-bit difference of {partial_rem[WIDTH-2:0], dividend MSB} minus the divisor.
  - If the difference is non-negative, the remainder takes the difference and quotient bit = 1. Otherwise the shifted remainder is kept and quotient bit = 0.
  - Shift the quotient left and increment the counter.
  - When the counter reaches WIDTH-1 and the step completes, go to DONE.
- Sign fixup, applied on entry to DONE:
  - The quotient is negated if the operand signs differ.
  - The remainder takes the dividend's sign.
  - All arithmetic is modulo 2^WIDTH, so 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- DIVZERO: architecturally undefined result. Load `result` = 64'h0 and go to DONE on the next edge.
- DONE:
  - `ready`=1 and `result` is stable.
  - Stay in DONE while `accept`=0. This covers i_stall/d_stall holding E.
  - On `accept`=1, clear `ready` and go to IDLE.
- `annul`=1 in any state forces IDLE and `ready`=0 on the next edge; `result` is not updated. `annul` takes priority over `start` and `accept`.
- `start` dropping while in DIVON/DIVZERO without `annul` aborts to IDLE with no result.
- Reset values: `result`=0, `ready`=0, counter=0, state=IDLE.

## Timing
- Latency:
  - Normal divide: with `start` first high in cycle t, `ready` is high from cycle t+WIDTH+1 (t+33). It stays high until the cycle after `accept`=1 is sampled in DONE.
  - Divide by zero: `ready` is high from cycle t+2.
- Back-to-back divides:
  - DONE→IDLE takes one edge. A second divide with `start` still high is sampled in IDLE at the next edge.
  - The second result's `ready` rises 33 cycles after the IDLE cycle.
- Operands are sampled only in IDLE. Later changes on `opdata1`/`opdata2` (forwarding updates) are ignored.
- Reset asserted mid-operation: outputs clear asynchronously and no partial result is visible.

## Test plan
- DIVU 100/7, `accept`=1 throughout: `ready` rises 33 cycles after `start` with `result`={32'd2, 32'd14}, then `ready` drops one cycle later.
- DIV -7/2 and 7/-2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF (for -7/2) and 0x00000001 (for 7/-2). DIV 0x80000000/0xFFFFFFFF gives {0, 0x80000000}.
- Divisor 0: `ready` high 2 cycles after `start`, `result`=0. The next DIVU 9/3 returns {0, 3}.
- Hold `accept`=0 for 10 cycles after `ready`: `ready` and `result` stay stable, with no restart despite `start`=1. Raise `accept`: the next edge leaves DONE.
- Pulse `annul` at iteration 15: `ready` never rises and state returns to IDLE. A new start produces a correct result with the full 33-cycle latency.
- Assert `rst` at iteration 20: `ready`=0 and `result`=0 immediately, before the next clock edge.
